halt_dump_controller: RTL

//  Responder for the processor's wait_for_continue / wait_continue_execution halt handshake.
//  On halt, reads data words 0..DUMP_WORDS-1 from data RAM and streams them out as bytes on a

---
 rtl/halt_dump_controller_if.sv | 27 ++
 rtl/halt_dump_controller.sv | 113 +++++++++++
 2 files changed

// File: rtl/halt_dump_controller_if.sv
// Signal bundle between the halt/dump controller and its surroundings: processor halt handshake,
// data-RAM read port and the byte stream. master = controller side, slave = processor/RAM/sink side.
interface halt_dump_controller_if #(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18
);
    logic                 wait_for_continue;
    logic                 wait_continue_execution;
    logic                 continue_req;
    logic                 mem_grant;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_dout;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [7:0]           tx_data;
    logic                 busy;

    modport master (
        input  wait_for_continue, continue_req, mem_dout, tx_ready,
        output wait_continue_execution, mem_grant, mem_addr, tx_valid, tx_data, busy
    );

    modport slave (
        output wait_for_continue, continue_req, mem_dout, tx_ready,
        input  wait_continue_execution, mem_grant, mem_addr, tx_valid, tx_data, busy
    );
endinterface

// File: rtl/halt_dump_controller.sv
// Answers a processor halt by streaming a header byte plus data words 0..DUMP_WORDS-1 (MSB-first bytes),
// then releases the processor with a one-cycle continue pulse (automatic or on host request).
module halt_dump_controller #(
    parameter int ADDR_SIZE     = 18,
    parameter int WORD_SIZE     = 18,
    parameter int DUMP_WORDS    = 64,
    parameter bit AUTO_CONTINUE = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    halt_dump_controller_if.master  bus
);
    localparam int BPW = (WORD_SIZE + 7) / 8;
    localparam int SW  = BPW * 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [ADDR_SIZE-1:0] LAST_INDEX  = ADDR_SIZE'(DUMP_WORDS - 1);
    localparam logic [BCW-1:0]       LAST_BYTE   = BCW'(BPW - 1);
    localparam logic [SW-1:0]        HEADER_WORD = SW'(8'hA5) << (SW - 8);

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_ADDR, S_READ, S_SEND, S_RESUME, S_WAIT_DROP
    } state_t;

    state_t               state;
    logic [ADDR_SIZE-1:0] index;
    logic [BCW-1:0]       byte_cnt;
    logic [SW-1:0]        shift_reg;
    logic                 accept;

    assign accept      = bus.tx_valid && bus.tx_ready;
    // The outgoing byte is always the top of the shift register; the header is loaded there too.
    assign bus.tx_data  = shift_reg[SW-1 -: 8];
    assign bus.mem_addr = index;

    // NOTE: all state and registered outputs use non-blocking assignments so every branch sees
    // the pre-edge values; the continue pulse defaults low each cycle so it can never stretch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                       <= S_IDLE;
            index                       <= '0;
            byte_cnt                    <= '0;
            shift_reg                   <= '0;
            bus.tx_valid                <= 1'b0;
            bus.mem_grant               <= 1'b0;
            bus.busy                    <= 1'b0;
            bus.wait_continue_execution <= 1'b0;
        end else begin
            bus.wait_continue_execution <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.wait_for_continue) begin
                        state        <= S_HEADER;
                        index        <= '0;
                        shift_reg    <= HEADER_WORD;
                        bus.tx_valid <= 1'b1;
                        bus.busy     <= 1'b1;
                    end
                end
                S_HEADER: begin
                    if (accept) begin
                        bus.tx_valid  <= 1'b0;
                        bus.mem_grant <= 1'b1;
                        state         <= S_ADDR;
                    end
                end
                S_ADDR: state <= S_READ;
                S_READ: begin
                    shift_reg     <= SW'(bus.mem_dout);
                    byte_cnt      <= '0;
                    bus.mem_grant <= 1'b0;
                    bus.tx_valid  <= 1'b1;
                    state         <= S_SEND;
                end
                S_SEND: begin
                    if (accept) begin
                        shift_reg <= shift_reg << 8;
                        byte_cnt  <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            bus.tx_valid <= 1'b0;
                            if (index == LAST_INDEX) begin
                                state <= S_RESUME;
                            end else begin
                                index         <= index + 1'b1;
                                bus.mem_grant <= 1'b1;
                                state         <= S_ADDR;
                            end
                        end
                    end
                end
                S_RESUME: begin
                    if (AUTO_CONTINUE || bus.continue_req) begin
                        bus.wait_continue_execution <= 1'b1;
                        state                       <= S_WAIT_DROP;
                    end
                end
                S_WAIT_DROP: begin
                    // Stay here until the halt is withdrawn so one halt yields exactly one dump.
                    if (!bus.wait_for_continue) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    bus.tx_valid  <= 1'b0;
                    bus.mem_grant <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
